// File: rtl/dpc_param.sv
// rtl/dpc_param.sv - banked complex matched-filter pulse compressor, one tap per cycle
module dpc_param #(
  parameter int DW    = 20,
  parameter int CW    = 16,
  parameter int OW    = 25,
  parameter int NTAP  = 64,
  parameter int NMODE = 4,
  parameter int SHIFT = 16,
  localparam int BW   = (NMODE > 1) ? $clog2(NMODE) : 1,
  localparam int AW   = $clog2(NTAP)
) (
  input  logic                 clk_200M,
  input  logic                 rst_n,
  input  logic                 pri,
  input  logic [BW-1:0]        mode,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] din_q,
  input  logic                 coef_we,
  input  logic [BW-1:0]        coef_bank,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_i,
  input  logic signed [CW-1:0] coef_q,
  output logic                 coef_err,
  output logic                 dout_valid,
  output logic signed [OW-1:0] dout_i,
  output logic signed [OW-1:0] dout_q,
  output logic                 sat
);

  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + AW + 1;
  localparam int RW   = ACCW + 1;
  localparam int MW   = $clog2(NMODE * NTAP);
  localparam logic signed [RW-1:0] RND  = RW'((SHIFT > 0) ? 1 : 0) << ((SHIFT > 0) ? SHIFT - 1 : 0);
  localparam logic signed [RW-1:0] OMAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_pri_d;
  logic [BW-1:0]          r_bank;
  logic [AW-1:0]          r_tap;
  logic signed [DW-1:0]   r_dl_i [NTAP];
  logic signed [DW-1:0]   r_dl_q [NTAP];
  logic signed [CW-1:0]   r_coef_i [NMODE*NTAP];
  logic signed [CW-1:0]   r_coef_q [NMODE*NTAP];
  logic signed [ACCW-1:0] r_acc_i, r_acc_q;
  logic signed [OW-1:0]   r_res_i, r_res_q, r_hold_i, r_hold_q;
  logic                   r_res_sat;
  logic                   r_coef_err;

  logic                   w_pri_rise, w_accept, w_coef_blk, w_coef_wr;
  logic [MW-1:0]          w_widx, w_ridx;
  logic signed [CW-1:0]   w_h_i, w_h_q;
  logic signed [DW-1:0]   w_x_i, w_x_q;
  logic signed [PW-1:0]   w_ac, w_bd, w_ad, w_bc;
  logic signed [ACCW-1:0] w_prod_i, w_prod_q;
  logic signed [RW-1:0]   w_shr_i, w_shr_q;
  logic [OW:0]            w_sat_i, w_sat_q;

  function automatic logic [OW:0] sat_fn(input logic signed [RW-1:0] v);
    if (v > OMAX) return {1'b1, OMAX[OW-1:0]};
    if (v < OMIN) return {1'b1, OMIN[OW-1:0]};
    return {1'b0, v[OW-1:0]};
  endfunction

  assign w_pri_rise = pri && !r_pri_d;
  assign din_ready  = (r_state == IDLE) && !w_pri_rise;
  assign w_accept   = din_valid && din_ready;

  // The bank feeding an in-flight computation is frozen; other banks stay writable.
  assign w_coef_blk = (coef_bank == r_bank) && (r_state != IDLE);
  assign w_coef_wr  = coef_we && !w_coef_blk && (int'(coef_addr) < NTAP);
  assign w_widx     = MW'(int'(coef_bank) * NTAP + int'(coef_addr));
  assign w_ridx     = MW'(int'(r_bank) * NTAP + int'(r_tap));

  always_ff @(posedge clk_200M) begin
    if (w_coef_wr) begin
      r_coef_i[w_widx] <= coef_i;
      r_coef_q[w_widx] <= coef_q;
    end
  end

  assign w_h_i    = r_coef_i[w_ridx];
  assign w_h_q    = r_coef_q[w_ridx];
  assign w_x_i    = r_dl_i[r_tap];
  assign w_x_q    = r_dl_q[r_tap];
  assign w_ac     = PW'(w_x_i) * PW'(w_h_i);
  assign w_bd     = PW'(w_x_q) * PW'(w_h_q);
  assign w_ad     = PW'(w_x_i) * PW'(w_h_q);
  assign w_bc     = PW'(w_x_q) * PW'(w_h_i);
  assign w_prod_i = ACCW'(w_ac) - ACCW'(w_bd);
  assign w_prod_q = ACCW'(w_ad) + ACCW'(w_bc);

  assign w_shr_i  = (RW'(r_acc_i) + RND) >>> SHIFT;
  assign w_shr_q  = (RW'(r_acc_q) + RND) >>> SHIFT;
  assign w_sat_i  = sat_fn(w_shr_i);
  assign w_sat_q  = sat_fn(w_shr_q);

  always_comb begin
    w_state_nxt = r_state;
    if (w_pri_rise) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (din_valid) w_state_nxt = MAC;
        MAC:     if (r_tap == AW'(NTAP - 1)) w_state_nxt = ROUND;
        ROUND:   w_state_nxt = OUT;
        OUT:     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_200M) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pri_d    <= 1'b0;
      r_bank     <= '0;
      r_tap      <= '0;
      r_acc_i    <= '0;
      r_acc_q    <= '0;
      r_res_i    <= '0;
      r_res_q    <= '0;
      r_res_sat  <= 1'b0;
      r_hold_i   <= '0;
      r_hold_q   <= '0;
      r_coef_err <= 1'b0;
      for (int k = 0; k < NTAP; k++) begin
        r_dl_i[k] <= '0;
        r_dl_q[k] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_pri_d    <= pri;
      r_coef_err <= coef_we && w_coef_blk;
      if (w_pri_rise) begin
        r_bank <= mode;
        for (int k = 0; k < NTAP; k++) begin
          r_dl_i[k] <= '0;
          r_dl_q[k] <= '0;
        end
      end else if (w_accept) begin
        for (int k = NTAP - 1; k > 0; k--) begin
          r_dl_i[k] <= r_dl_i[k-1];
          r_dl_q[k] <= r_dl_q[k-1];
        end
        r_dl_i[0] <= din_i;
        r_dl_q[0] <= din_q;
      end
      if (w_accept) begin
        r_tap   <= '0;
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else if (r_state == MAC) begin
        r_tap   <= r_tap + AW'(1);
        r_acc_i <= r_acc_i + w_prod_i;
        r_acc_q <= r_acc_q + w_prod_q;
      end
      if (r_state == ROUND) begin
        r_res_i   <= w_sat_i[OW-1:0];
        r_res_q   <= w_sat_q[OW-1:0];
        r_res_sat <= w_sat_i[OW] || w_sat_q[OW];
      end
      // The held value only advances once a result survives its OUT cycle.
      if (r_state == OUT && !w_pri_rise) begin
        r_hold_i <= r_res_i;
        r_hold_q <= r_res_q;
      end
    end
  end

  assign dout_valid = (r_state == OUT) && !w_pri_rise;
  assign dout_i     = dout_valid ? r_res_i : r_hold_i;
  assign dout_q     = dout_valid ? r_res_q : r_hold_q;
  assign sat        = dout_valid && r_res_sat;
  assign coef_err   = r_coef_err;

endmodule

// File: doc/dpc_param.md
DPC_PARAM -- requirements
Module: dpc_param

Interface
REQ-001 Parameter DW, default 20: input I/Q sample width, signed two's complement.
REQ-002 Parameter CW, default 16: coefficient I/Q width, signed.
REQ-003 Parameter OW, default 25: output I/Q width, signed.
REQ-004 Parameter NTAP, default 64: matched-filter length, range 2..256.
REQ-005 Parameter NMODE, default 4: number of coefficient banks (waveform modes), power of 2.
REQ-006 Parameter SHIFT, default 16: arithmetic right shift applied to the accumulator before saturation.
REQ-007 clk_200M  in  1  sole clock; all logic on its rising edge.
REQ-008 rst_n  in  1  synchronous, active-low reset.
REQ-009 pri  in  1  pulse repetition marker, level, synchronous to clk_200M.
REQ-010 mode  in  clog2(NMODE)  requested coefficient bank, sampled on pri rising edge.
REQ-011 din_valid / din_ready  in / out  1 / 1  input sample handshake.
REQ-012 din_i, din_q  in  DW each  complex input sample (DDC output).
REQ-013 coef_we  in  1  coefficient write strobe.
REQ-014 coef_bank, coef_addr  in  clog2(NMODE), clog2(NTAP)  write target bank / tap index.
REQ-015 coef_i, coef_q  in  CW each  coefficient value.
REQ-016 coef_err  out  1  one-cycle pulse: write rejected.
REQ-017 dout_valid  out  1  one-cycle pulse: dout_i/dout_q valid.
REQ-018 dout_i, dout_q  out  OW each  compressed output, held between pulses.
REQ-019 sat  out  1  high with dout_valid when either component saturated.

Function
REQ-020 Output SHALL be y[n] = sum over k=0..NTAP-1 of h[bank][k]*x[n-k]; delay-line slot 0 holds the newest sample.
REQ-021 Complex product SHALL be (a+bi)(c+di) = (ac-bd) + (ad+bc)i, exact, full width.
REQ-022 Accumulators SHALL be DW+CW+clog2(NTAP)+1 bits; no overflow inside the sum.
REQ-023 Output scaling: add 2^(SHIFT-1) when SHIFT>0, arithmetic shift right by SHIFT, saturate to [-2^(OW-1), 2^(OW-1)-1] per component.
REQ-024 FSM states IDLE, MAC, ROUND, OUT; reset state IDLE.
REQ-025 din_ready SHALL equal (state==IDLE) AND NOT pri_rise.
REQ-026 Accept at cycle T: sample shifts into slot 0 at T; MAC runs T+1..T+NTAP, one tap per cycle; ROUND at T+NTAP+1; OUT at T+NTAP+2 with dout_valid=1; IDLE at T+NTAP+3.
REQ-027 Maximum throughput SHALL be one sample per NTAP+3 cycles; din_valid while din_ready=0 is ignored, not queued.
REQ-028 pri_rise = pri AND NOT pri registered on the previous cycle.
REQ-029 On pri_rise: clear all delay-line slots to 0 in that cycle, latch mode into the active bank, go to IDLE.
REQ-030 pri_rise in MAC/ROUND/OUT SHALL abort: no dout_valid for that sample, dout_i/dout_q keep their previous values.
REQ-031 pri_rise coincident with din_valid: sample not accepted (din_ready=0); clear and mode latch take effect.
REQ-032 coef_we SHALL write bank[coef_bank][coef_addr] in one cycle, readable on the next cycle.
REQ-033 coef_we to the active bank while state != IDLE SHALL be dropped, with coef_err=1 on the next cycle; writes to other banks are always accepted.
REQ-034 Active bank SHALL change only on pri_rise, never mid-computation.
REQ-035 sat SHALL be 0 whenever dout_valid=0.

Reset
REQ-036 While rst_n=0 at a clock edge: state=IDLE, delay line=0, active bank=0, pri register=0, dout_valid=0, dout_i=dout_q=0, sat=0, coef_err=0.
REQ-037 Coefficient memory SHALL NOT be cleared by reset.
REQ-038 Reset asserted mid-MAC SHALL abort with no dout_valid; din_ready=1 on the first cycle after rst_n returns to 1.

Verification
REQ-039 Impulse test. Setup: NTAP=8, SHIFT=0, bank 0 h[k]=(k+1)+0i. Stimulus: pri pulse, then x=1+0i, then seven samples of 0. Required: dout_i=1,2,...,8 and dout_q=0; each dout_valid exactly NTAP+2 cycles after acceptance.
REQ-040 Complex product test. Setup: h[0]=3+4i, all other taps 0. Stimulus: x=1+2i. Required: dout=-5+10i.
REQ-041 Saturation test. Setup: SHIFT=0, OW=25, all h=(2^(CW-1)-1)+0i. Stimulus: full-scale positive x. Required: dout_i=2^24-1 with sat=1; the negative case gives -2^24.
REQ-042 Abort test. Stimulus: pri_rise at T+5 of a MAC. Required: no dout_valid; next impulse response equals REQ-039 with no residue.
REQ-043 Bank test. Setup: bank 1 h[0]=2. Stimulus: mode=1 at pri_rise, then x=1. Required: dout_i=2. A write to bank 1 during MAC gives coef_err=1 and leaves bank 1 unchanged; a write to bank 2 succeeds.
REQ-044 Reset test. Stimulus: rst_n=0 for 1 cycle mid-MAC. Required: all outputs 0 and din_ready=1 on the next cycle; coefficients intact.
